adxl362_stream: RTL

//  Parametrised ADXL362 accelerometer controller with its own SPI mode-0 byte engine. After reset it

---
 rtl/adxl362_stream.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/adxl362_stream.sv
// ADXL362 controller: checks DEVID, writes FILTER_CTL/POWER_CTL, then burst-reads the axes
// (optionally temperature) on a fixed tick through a built-in SPI mode-0 byte engine.
module adxl362_stream #(
  parameter int P_CLKFREQ  = 100_000_000,
  parameter int P_SCLKFREQ = 1_000_000,
  parameter int P_READFREQ = 1_000,
  parameter int P_NCH      = 3,
  parameter int P_RANGE    = 0,
  parameter int P_ODR      = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  input  logic                 miso_i,
  output logic                 mosi_o,
  output logic                 sclk_o,
  output logic                 cs_o,
  output logic [16*P_NCH-1:0]  data_o,
  output logic                 valid_o,
  output logic [15:0]          sample_cnt_o,
  output logic [7:0]           drop_cnt_o,
  output logic                 cfg_done_o,
  output logic                 id_err_o
);
  localparam int H        = P_CLKFREQ / (2 * P_SCLKFREQ);
  localparam int T        = P_CLKFREQ / P_READFREQ;
  localparam int NB_CFG   = 3;
  localparam int NB_BURST = 2 + 2 * P_NCH;
  localparam int DW       = 16 * P_NCH;
  localparam int CW       = $clog2(2 * H + 1);
  localparam int TW       = $clog2(T + 1);
  localparam int BW       = $clog2(NB_BURST + 1);
  localparam logic [7:0] FILTER_VAL = {P_RANGE[1:0], 3'b000, P_ODR[2:0]};

  typedef enum logic [2:0] {S_ID, S_FILT, S_PWR, S_WAIT, S_BURST, S_ERR} state_e;
  typedef enum logic [2:0] {E_IDLE, E_LEAD, E_SHIFT, E_TRAIL, E_GAP} phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            cs_q, cs_d, sclk_q, sclk_d;
  logic [7:0]      tx_q, tx_d, rx_q, rx_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [DW-1:0]   shadow_q, shadow_d, data_q, data_d;
  logic            id_ok_q, id_ok_d, valid_q, valid_d;
  logic            cfg_done_q, cfg_done_d, id_err_q, id_err_d;
  logic [15:0]     sample_q, sample_d;
  logic [7:0]      drop_q, drop_d;
  logic            tick;
  logic [BW-1:0]   nb_last;

  // Command byte sent at position idx of the transaction owned by state st.
  function automatic logic [7:0] tx_byte(input state_e st, input logic [BW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    unique case (st)
      S_ID:    b = (idx == '0) ? 8'h0B : 8'h00;
      S_FILT:  b = (idx == '0) ? 8'h0A : (idx == BW'(1)) ? 8'h2C : FILTER_VAL;
      S_PWR:   b = (idx == '0) ? 8'h0A : (idx == BW'(1)) ? 8'h2D : 8'h02;
      S_BURST: b = (idx == '0) ? 8'h0B : (idx == BW'(1)) ? 8'h0E : 8'h00;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign tick    = (tick_cnt_q == TW'(T - 1));
  assign nb_last = (state_q == S_BURST) ? BW'(NB_BURST - 1) : BW'(NB_CFG - 1);

  // NOTE: every variable gets its default before any branch, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shadow_d   = shadow_q;
    id_ok_d    = id_ok_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sample_d   = sample_q;
    drop_d     = drop_q;
    cfg_done_d = cfg_done_q;
    id_err_d   = id_err_q;

    if (tick && enable_i && state_q == S_BURST && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    if (tick && enable_i && state_q == S_WAIT) state_d = S_BURST;

    unique case (phase_q)
      E_IDLE: begin
        if (state_q inside {S_ID, S_FILT, S_PWR, S_BURST}) begin
          cs_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = tx_byte(state_q, '0);
          phase_d = E_LEAD;
        end
      end
      E_LEAD: begin
        if (cnt_q == CW'(H - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso_i};
          phase_d = E_SHIFT;
        end else cnt_d = cnt_q + 1'b1;
      end
      E_SHIFT: begin
        if (cnt_q == CW'(H - 1)) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], miso_i};
          end else if (bit_q == 3'd7) begin
            // Falling edge closing a byte: rx_q already holds all eight sampled bits.
            bit_d = '0;
            if (state_q == S_ID && byte_q == BW'(2)) id_ok_d = (rx_q == 8'hAD);
            if (state_q == S_BURST) begin
              for (int k = 0; k < 2 * P_NCH; k++)
                if (byte_q == BW'(k + 2)) shadow_d[8*k +: 8] = rx_q;
            end
            if (byte_q == nb_last) begin
              tx_d    = 8'h00;
              phase_d = E_TRAIL;
            end else begin
              byte_d = byte_q + 1'b1;
              tx_d   = tx_byte(state_q, byte_q + 1'b1);
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      E_TRAIL: begin
        if (cnt_q == CW'(H - 1)) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          phase_d = E_GAP;
          unique case (state_q)
            S_ID: begin
              if (id_ok_q) state_d = S_FILT;
              else begin
                id_err_d = 1'b1;
                state_d  = S_ERR;
              end
            end
            S_FILT: state_d = S_PWR;
            S_PWR: begin
              cfg_done_d = 1'b1;
              state_d    = S_WAIT;
            end
            S_BURST: begin
              data_d   = shadow_q;
              valid_d  = 1'b1;
              sample_d = sample_q + 1'b1;
              state_d  = S_WAIT;
            end
            default: ;
          endcase
        end else cnt_d = cnt_q + 1'b1;
      end
      E_GAP: begin
        if (cnt_q == CW'(2 * H - 1)) begin
          cnt_d   = '0;
          phase_d = E_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: phase_d = E_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_ID;
      phase_q    <= E_IDLE;
      cnt_q      <= '0;
      tick_cnt_q <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shadow_q   <= '0;
      id_ok_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sample_q   <= '0;
      drop_q     <= '0;
      cfg_done_q <= 1'b0;
      id_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shadow_q   <= shadow_d;
      id_ok_q    <= id_ok_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sample_q   <= sample_d;
      drop_q     <= drop_d;
      cfg_done_q <= cfg_done_d;
      id_err_q   <= id_err_d;
    end
  end

  assign mosi_o       = tx_q[7];
  assign sclk_o       = sclk_q;
  assign cs_o         = cs_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign sample_cnt_o = sample_q;
  assign drop_cnt_o   = drop_q;
  assign cfg_done_o   = cfg_done_q;
  assign id_err_o     = id_err_q;
endmodule
